// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the DataMem arbiter: FSM state encoding, port ids
// and the wait-counter width helper.
package dmem_arbiter_pkg;

  // FSM states of the access sequencer.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Requester ids; also used as bit positions in the grant vector.
  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

  // Counter width large enough to hold the larger of the two wait loads.
  function automatic int cnt_width(input int rd_wait, input int wr_wait);
    int max_wait;
    max_wait = (rd_wait > wr_wait) ? rd_wait : wr_wait;
    return $clog2(max_wait) + 1;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the DataMem arbiter: two identical request/ack
// ports (p0 = CPU load/store unit, p1 = loader/debug master).
//  pX_req   requester -> arbiter  request, held high until pX_ack
//  pX_we    requester -> arbiter  1 = write, 0 = read
//  pX_addr  requester -> arbiter  byte address
//  pX_wdata requester -> arbiter  write data
//  pX_ack   arbiter -> requester  one-cycle completion pulse
//  pX_rdata arbiter -> requester  read data, valid with ack, held until next read
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_ack;
  logic [DATA_W-1:0] p0_rdata;

  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_ack;
  logic [DATA_W-1:0] p1_rdata;

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_ack, p0_rdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_ack, p1_rdata
  );

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_ack, p0_rdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_ack, p1_rdata
  );
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-input round-robin grant, purely combinational.
//  req  in  2  request vector, bit index = port id
//  last in  1  port granted most recently
//  gnt  out 2  one-hot grant (all zero when nobody requests)
module dmem_arbiter_rr_arb2
  import dmem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // A lone requester always wins; on a tie the port that was not last wins.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11: begin
        if (last == P1) begin
          gnt = 2'b01;
        end else begin
          gnt = 2'b10;
        end
      end
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of a single-ported DataMem
// (asynchronous read, negedge write). One access at a time, round-robin
// between the ports; address/control are held for a fixed wait count, then
// the granted port receives a one-cycle ack (plus read data on reads).
//  clk      in   1       rising-edge clock
//  rst      in   1       asynchronous reset, active high
//  bus      slave        requester ports p0/p1
//  mem_addr out  ADDR_W  DataMem address (retains last value)
//  mem_rd   out  1       DataMem read strobe
//  mem_wr   out  1       DataMem write strobe
//  mem_din  out  DATA_W  DataMem write data (retains last value)
//  mem_dout in   DATA_W  DataMem read data
//  busy     out  1       high while an access is in progress
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  dmem_arbiter_if.slave     bus,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy
);

  localparam int CNT_W = cnt_width(RD_WAIT, WR_WAIT);
  // Counter loads WAIT-1 so the strobe is high for exactly WAIT cycles.
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_WAIT - 1);

  state_t            state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              sel_r;
  logic              we_r;
  logic              last_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic              mem_rd_r;
  logic              mem_wr_r;
  logic [DATA_W-1:0] mem_din_r;
  logic              p0_ack_r;
  logic              p1_ack_r;
  logic [DATA_W-1:0] p0_rdata_r;
  logic [DATA_W-1:0] p1_rdata_r;
  logic              busy_r;

  logic [1:0]        gnt_s;
  logic              sel_s;
  logic              req_we_s;
  logic [ADDR_W-1:0] req_addr_s;
  logic [DATA_W-1:0] req_wdata_s;

  dmem_arbiter_rr_arb2 u_rr (
    .req  ({bus.p1_req, bus.p0_req}),
    .last (last_r),
    .gnt  (gnt_s)
  );

  // Route the granted port's request fields toward the latch registers.
  always_comb begin
    sel_s       = P0;
    req_we_s    = bus.p0_we;
    req_addr_s  = bus.p0_addr;
    req_wdata_s = bus.p0_wdata;
    if (gnt_s[P1]) begin
      sel_s       = P1;
      req_we_s    = bus.p1_we;
      req_addr_s  = bus.p1_addr;
      req_wdata_s = bus.p1_wdata;
    end else begin
      sel_s       = P0;
      req_we_s    = bus.p0_we;
      req_addr_s  = bus.p0_addr;
      req_wdata_s = bus.p0_wdata;
    end
  end

  // Access sequencer: grant, hold strobes for the wait count, ack, recover.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      cnt_r      <= '0;
      sel_r      <= P0;
      we_r       <= 1'b0;
      last_r     <= P1;
      mem_addr_r <= '0;
      mem_rd_r   <= 1'b0;
      mem_wr_r   <= 1'b0;
      mem_din_r  <= '0;
      p0_ack_r   <= 1'b0;
      p1_ack_r   <= 1'b0;
      p0_rdata_r <= '0;
      p1_rdata_r <= '0;
      busy_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (gnt_s != 2'b00) begin
            sel_r      <= sel_s;
            we_r       <= req_we_s;
            last_r     <= sel_s;
            mem_addr_r <= req_addr_s;
            mem_din_r  <= req_wdata_s;
            mem_rd_r   <= ~req_we_s;
            mem_wr_r   <= req_we_s;
            cnt_r      <= req_we_s ? WR_LOAD : RD_LOAD;
            busy_r     <= 1'b1;
            state_r    <= ST_ACCESS;
          end else begin
            state_r    <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          if (cnt_r != '0) begin
            cnt_r <= cnt_r - CNT_W'(1);
          end else begin
            mem_rd_r <= 1'b0;
            mem_wr_r <= 1'b0;
            // Read data is sampled while mem_rd is still asserted.
            if (!we_r) begin
              if (sel_r == P1) begin
                p1_rdata_r <= mem_dout;
              end else begin
                p0_rdata_r <= mem_dout;
              end
            end
            if (sel_r == P1) begin
              p1_ack_r <= 1'b1;
            end else begin
              p0_ack_r <= 1'b1;
            end
            state_r <= ST_DONE;
          end
        end
        ST_DONE: begin
          // One dead cycle lets the requester drop req before re-arbitration.
          p0_ack_r <= 1'b0;
          p1_ack_r <= 1'b0;
          busy_r   <= 1'b0;
          state_r  <= ST_IDLE;
        end
        default: begin
          mem_rd_r <= 1'b0;
          mem_wr_r <= 1'b0;
          p0_ack_r <= 1'b0;
          p1_ack_r <= 1'b0;
          busy_r   <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_addr     = mem_addr_r;
  assign mem_rd       = mem_rd_r;
  assign mem_wr       = mem_wr_r;
  assign mem_din      = mem_din_r;
  assign busy         = busy_r;
  assign bus.p0_ack   = p0_ack_r;
  assign bus.p1_ack   = p1_ack_r;
  assign bus.p0_rdata = p0_rdata_r;
  assign bus.p1_rdata = p1_rdata_r;

endmodule
